// File: rtl/display_scan_capture.sv
// display_scan_capture
// Rebuilds a four-digit multiplexed display frame from the scanned digit bus.
// The bus is sampled once into local registers. A digit slot is written once
// the select pattern has stayed stable long enough. Illegal stable patterns
// and a silent bus are both reported.
module display_scan_capture #(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  AN,
  input  logic [3:0]  HEX,
  input  logic        P,
  input  logic        LE,
  output logic [15:0] Hexs,
  output logic [3:0]  Point,
  output logic [3:0]  LES,
  output logic        Valid,
  output logic        FrameDone,
  output logic        Err,
  output logic [7:0]  ErrCnt,
  output logic        Stale
);

  localparam logic [3:0]  SETTLE_V   = 4'(SETTLE);
  localparam logic [3:0]  SETTLE_M1  = 4'(SETTLE - 1);
  localparam logic [15:0] TIMEOUT_V  = 16'(TIMEOUT);
  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

  logic [3:0]  an_q;
  logic [3:0]  hex_q;
  logic        p_q;
  logic        le_q;
  logic [3:0]  dwell;
  logic [3:0]  frame_mask;
  logic [15:0] stale_cnt;

  logic [3:0]  digit_sel;
  logic        is_illegal;
  logic        an_change;
  logic        crossing;
  logic        capture;
  logic        illegal_hit;
  logic [3:0]  mask_set;
  logic        frame_full;
  logic        expire;

  // Register the raw scan bus once; every decision below uses these copies.
  // NOTE: sequential state is always written with <= so every register sees
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= 4'hF;
      hex_q <= 4'h0;
      p_q   <= 1'b0;
      le_q  <= 1'b0;
    end else begin
      an_q  <= AN;
      hex_q <= HEX;
      p_q   <= P;
      le_q  <= LE;
    end
  end

  // Decode the registered select pattern into a one-hot digit or an illegal flag.
  // NOTE: both outputs get a default before the case, so no path leaves them
  // unassigned and no latch is inferred.
  always_comb begin
    digit_sel  = 4'b0000;
    is_illegal = 1'b0;
    case (an_q)
      4'b1110: digit_sel = 4'b0001;
      4'b1101: digit_sel = 4'b0010;
      4'b1011: digit_sel = 4'b0100;
      4'b0111: digit_sel = 4'b1000;
      4'b1111: ;
      default: is_illegal = 1'b1;
    endcase
  end

  // Event qualification: a capture or error fires once, on the edge where the
  // dwell count crosses into SETTLE without the pattern changing.
  always_comb begin
    an_change   = (AN != an_q);
    crossing    = !an_change && (dwell == SETTLE_M1);
    capture     = crossing && (digit_sel != 4'b0000);
    illegal_hit = crossing && is_illegal;
    mask_set    = frame_mask | digit_sel;
    frame_full  = capture && (mask_set == 4'hF);
    expire      = !capture && (stale_cnt == TIMEOUT_M1);
  end

  // Dwell counter: restarts whenever the registered pattern changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell <= 4'd0;
    end else if (an_change) begin
      dwell <= 4'd0;
    end else if (dwell != SETTLE_V) begin
      dwell <= dwell + 4'd1;
    end
  end

  // Digit slots: only the selected digit is overwritten on a capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Hexs  <= 16'h0000;
      Point <= 4'h0;
      LES   <= 4'h0;
    end else if (capture) begin
      for (int n = 0; n < 4; n++) begin
        if (digit_sel[n]) begin
          Hexs[4*n +: 4] <= hex_q;
          Point[n]       <= p_q;
          LES[n]         <= le_q;
        end
      end
    end
  end

  // Frame tracking: mask accumulates captures; completion pulses FrameDone
  // and sets Valid. Errors and timeouts discard the partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_mask <= 4'h0;
      Valid      <= 1'b0;
      FrameDone  <= 1'b0;
    end else begin
      FrameDone <= frame_full;
      if (illegal_hit || expire) begin
        frame_mask <= 4'h0;
        Valid      <= 1'b0;
      end else if (capture) begin
        frame_mask <= frame_full ? 4'h0 : mask_set;
        if (frame_full) begin
          Valid <= 1'b1;
        end
      end
    end
  end

  // Error pulse and saturating error count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Err    <= 1'b0;
      ErrCnt <= 8'h00;
    end else begin
      Err <= illegal_hit;
      if (illegal_hit && (ErrCnt != 8'hFF)) begin
        ErrCnt <= ErrCnt + 8'h01;
      end
    end
  end

  // Stale watchdog: a capture on the expiry edge takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stale_cnt <= 16'h0000;
      Stale     <= 1'b0;
    end else if (capture) begin
      stale_cnt <= 16'h0000;
      Stale     <= 1'b0;
    end else begin
      if (stale_cnt != TIMEOUT_V) begin
        stale_cnt <= stale_cnt + 16'h0001;
      end
      if (expire) begin
        Stale <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_capture.sv
// Bench for display_scan_capture: directed scenarios plus randomized scans,
// all compared each cycle against a sample-history reference model.
module tb_display_scan_capture;

  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [3:0]  hex;
  logic        p;
  logic        le;
  logic [15:0] hexs;
  logic [3:0]  point;
  logic [3:0]  les;
  logic        valid;
  logic        frame_done;
  logic        err;
  logic [7:0]  err_cnt;
  logic        stale;
  logic [35:0] obs;

  int errors = 0;
  int checks = 0;

  display_scan_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .AN        (an),
    .HEX       (hex),
    .P         (p),
    .LE        (le),
    .Hexs      (hexs),
    .Point     (point),
    .LES       (les),
    .Valid     (valid),
    .FrameDone (frame_done),
    .Err       (err),
    .ErrCnt    (err_cnt),
    .Stale     (stale)
  );

  assign obs = {hexs, point, les, valid, frame_done, err, err_cnt, stale};

  always #5 clk = ~clk;

  // Reference model: a history of sampled select patterns. A digit or error
  // event happens when the newest run of identical samples reaches exactly
  // SETTLE+1 (reset counts as the start of a run of 1111). Captured data is
  // the HEX/P/LE sampled one edge earlier.
  logic [3:0] an_hist[$];
  logic [3:0] m_hex[4];
  logic [3:0] m_pt, m_le, m_mask;
  logic       m_valid, m_fd, m_err, m_stale;
  int         m_errcnt, m_since;
  logic [3:0] prev_hex;
  logic       prev_p, prev_le;

  function automatic void model_reset();
    an_hist.delete();
    an_hist.push_back(4'hF);
    for (int i = 0; i < 4; i++) m_hex[i] = 4'h0;
    m_pt = 0; m_le = 0; m_mask = 0;
    m_valid = 0; m_fd = 0; m_err = 0; m_stale = 0;
    m_errcnt = 0; m_since = 0;
    prev_hex = 0; prev_p = 0; prev_le = 0;
  endfunction

  function automatic void model_edge();
    logic [3:0] cur;
    int run;
    int d;
    cur = an;
    an_hist.push_back(cur);
    if (an_hist.size() > 20) void'(an_hist.pop_front());
    run = 0;
    for (int i = an_hist.size() - 1; i >= 0; i--) begin
      if (an_hist[i] != cur) break;
      run++;
    end
    m_fd  = 0;
    m_err = 0;
    if (run == SETTLE + 1 && cur != 4'hF && $countones(cur) == 3) begin
      d = 0;
      for (int i = 0; i < 4; i++) if (!cur[i]) d = i;
      m_hex[d] = prev_hex;
      m_pt[d]  = prev_p;
      m_le[d]  = prev_le;
      m_mask[d] = 1'b1;
      m_since = 0;
      m_stale = 0;
      if (m_mask == 4'hF) begin
        m_fd = 1; m_valid = 1; m_mask = 0;
      end
    end else begin
      if (run == SETTLE + 1 && cur != 4'hF) begin
        m_err = 1;
        if (m_errcnt < 255) m_errcnt++;
        m_mask = 0;
        m_valid = 0;
      end
      if (m_since < TIMEOUT) begin
        m_since++;
        if (m_since == TIMEOUT) begin
          m_stale = 1; m_valid = 0; m_mask = 0;
        end
      end
    end
    prev_hex = hex; prev_p = p; prev_le = le;
  endfunction

  function automatic logic [35:0] exp_vec();
    logic [7:0] ec;
    ec = m_errcnt[7:0];
    return {m_hex[3], m_hex[2], m_hex[1], m_hex[0], m_pt, m_le,
            m_valid, m_fd, m_err, ec, m_stale};
  endfunction

  // Model tracks every rising edge, whether or not a task is driving.
  always @(posedge clk) begin
    if (rst) model_reset();
    else     model_edge();
  end

  task automatic step(input logic [3:0] a, input logic [3:0] h, input logic pp, input logic ll);
    @(negedge clk);
    an = a; hex = h; p = pp; le = ll;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    an = 4'hF; hex = 4'h0; p = 1'b0; le = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic scan_frame(input string name, input logic [15:0] hv, input logic [3:0] pv,
                            output int fd_count);
    logic [3:0] pats[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    fd_count = 0;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 8; c++) begin
        step(pats[d], hv[4*d +: 4], pv[d], 1'b1);
        checks++;
        if (obs !== exp_vec()) begin
          errors++;
          $display("FAIL %s digit%0d cyc%0d: got %h want %h", name, d, c, obs, exp_vec());
        end
        if (frame_done) fd_count++;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (obs !== 36'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", obs);
    end
    do_reset();
  endtask

  task automatic test_scan();
    int fdc;
    do_reset();
    scan_frame("scan", 16'h4321, 4'b1001, fdc);
    checks++;
    if (hexs !== 16'h4321) begin errors++; $display("FAIL scan_hexs: got %h want 4321", hexs); end
    checks++;
    if (point !== 4'b1001) begin errors++; $display("FAIL scan_point: got %b want 1001", point); end
    checks++;
    if (les !== 4'b1111) begin errors++; $display("FAIL scan_les: got %b want 1111", les); end
    checks++;
    if (fdc !== 1) begin errors++; $display("FAIL scan_framedone_count: got %0d want 1", fdc); end
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL scan_valid: got %b want 1", valid); end
  endtask

  task automatic test_short_dwell();
    int fdc;
    int errs_seen;
    do_reset();
    scan_frame("short_pre", 16'h4321, 4'b1001, fdc);
    errs_seen = 0;
    step(4'b1110, 4'h7, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(4'b1111, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL short_dwell cyc%0d: got %h want %h", c, obs, exp_vec());
      end
      if (err) errs_seen++;
    end
    checks++;
    if (hexs !== 16'h4321) begin errors++; $display("FAIL short_hexs: got %h want 4321", hexs); end
    checks++;
    if (errs_seen !== 0) begin errors++; $display("FAIL short_err: got %0d want 0", errs_seen); end
  endtask

  task automatic test_illegal();
    int fdc;
    int errs_seen;
    do_reset();
    scan_frame("illegal_pre", 16'h4321, 4'b1001, fdc);
    errs_seen = 0;
    for (int c = 0; c < 7; c++) begin
      step((c < 5) ? 4'b1100 : 4'b1111, 4'($urandom_range(0, 15)), 1'b1, 1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL illegal cyc%0d: got %h want %h", c, obs, exp_vec());
      end
      if (err) errs_seen++;
    end
    checks++;
    if (errs_seen !== 1) begin errors++; $display("FAIL illegal_err_pulses: got %0d want 1", errs_seen); end
    checks++;
    if (err_cnt !== 8'd1) begin errors++; $display("FAIL illegal_errcnt: got %0d want 1", err_cnt); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL illegal_valid: got %b want 0", valid); end
    checks++;
    if (hexs !== 16'h4321) begin errors++; $display("FAIL illegal_hexs: got %h want 4321", hexs); end
  endtask

  task automatic test_stale();
    int fdc;
    do_reset();
    scan_frame("stale_pre", 16'h8765, 4'b0110, fdc);
    for (int c = 0; c < TIMEOUT; c++) begin
      step(4'b1111, 4'h0, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL stale_idle cyc%0d: got %h want %h", c, obs, exp_vec());
      end
    end
    checks++;
    if (stale !== 1'b1) begin errors++; $display("FAIL stale_set: got %b want 1", stale); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL stale_valid: got %b want 0", valid); end
    for (int c = 0; c < 3; c++) step(4'b1110, 4'hA, 1'b1, 1'b1);
    checks++;
    if (stale !== 1'b0) begin errors++; $display("FAIL stale_clear: got %b want 0", stale); end
    checks++;
    if (hexs[3:0] !== 4'hA) begin errors++; $display("FAIL stale_recapture: got %h want a", hexs[3:0]); end
  endtask

  task automatic test_capture_vs_stale();
    do_reset();
    for (int c = 0; c < 3; c++) step(4'b1110, 4'h3, 1'b0, 1'b1);
    for (int c = 0; c < TIMEOUT - 3; c++) step(4'b1111, 4'h0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(4'b1101, 4'h6, 1'b1, 1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL cap_vs_stale cyc%0d: got %h want %h", c, obs, exp_vec());
      end
    end
    checks++;
    if (stale !== 1'b0) begin errors++; $display("FAIL cap_vs_stale_stale: got %b want 0", stale); end
    checks++;
    if (hexs[7:4] !== 4'h6) begin errors++; $display("FAIL cap_vs_stale_hexs: got %h want 6", hexs[7:4]); end
  endtask

  task automatic test_reset_mid_frame();
    int fdc;
    int fd_partial;
    do_reset();
    for (int c = 0; c < 4; c++) step(4'b1110, 4'h1, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) step(4'b1101, 4'h2, 1'b1, 1'b1);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs !== 36'h0) begin errors++; $display("FAIL midreset_outputs: got %h want 0", obs); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    fd_partial = 0;
    for (int c = 0; c < 8; c++) begin
      step((c < 4) ? 4'b1011 : 4'b0111, 4'h5, 1'b0, 1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL midreset_partial cyc%0d: got %h want %h", c, obs, exp_vec());
      end
      if (frame_done) fd_partial++;
    end
    checks++;
    if (fd_partial !== 0) begin errors++; $display("FAIL midreset_stale_mask: got %0d want 0", fd_partial); end
    scan_frame("midreset_scan", 16'hBEEF, 4'b0101, fdc);
    checks++;
    if (fdc !== 1) begin errors++; $display("FAIL midreset_framedone: got %0d want 1", fdc); end
  endtask

  task automatic test_hex_change();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      step((c < 6) ? 4'b1101 : 4'b1111, (c < 3) ? 4'h5 : 4'h9, 1'b0, 1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL hex_change cyc%0d: got %h want %h", c, obs, exp_vec());
      end
    end
    checks++;
    if (hexs[7:4] !== 4'h5) begin errors++; $display("FAIL hex_change_slot: got %h want 5", hexs[7:4]); end
  endtask

  task automatic test_errcnt_saturate();
    do_reset();
    for (int k = 0; k < 260; k++) begin
      for (int c = 0; c < 3; c++) step(4'b1100, 4'h0, 1'b0, 1'b0);
      step(4'b1111, 4'h0, 1'b0, 1'b0);
    end
    checks++;
    if (err_cnt !== 8'd255) begin errors++; $display("FAIL errcnt_saturate: got %0d want 255", err_cnt); end
  endtask

  task automatic test_random();
    logic [3:0] pats[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] a;
    logic [3:0] h;
    int len;
    int sel;
    do_reset();
    for (int k = 0; k < 200; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      a = pats[$urandom_range(0, 3)];
      else if (sel < 8) a = 4'hF;
      else              a = 4'($urandom_range(0, 15));
      len = int'($urandom_range(1, 6));
      h = 4'($urandom_range(0, 15));
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 3) == 0) h = 4'($urandom_range(0, 15));
        step(a, h, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        checks++;
        if (obs !== exp_vec()) begin
          errors++;
          $display("FAIL random dwell%0d cyc%0d: got %h want %h", k, c, obs, exp_vec());
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    an = 4'hF; hex = 4'h0; p = 1'b0; le = 1'b0;
    test_reset();
    test_scan();
    test_short_dwell();
    test_illegal();
    test_stale();
    test_capture_vs_stale();
    test_reset_mid_frame();
    test_hex_change();
    test_errcnt_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_scan_capture.md
DISPLAY_SCAN_CAPTURE -- requirements
Module: display_scan_capture

Interface
REQ-001 Parameter: SETTLE, default 2, cycles a digit-select pattern must stay stable before capture (legal range 1..15).
REQ-002 Parameter: TIMEOUT, default 1024, cycles without a capture before the bus is declared stale (legal range 16..65535).
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: AN  input  4  scanned digit select, active-low, synchronous to clk.
REQ-006 Port: HEX  input  4  hex value of the currently selected digit.
REQ-007 Port: P  input  1  point bit of the currently selected digit.
REQ-008 Port: LE  input  1  enable bit of the currently selected digit.
REQ-009 Port: Hexs  output  16  reconstructed digits; digit n in bits [4n+3:4n].
REQ-010 Port: Point  output  4  reconstructed point bits; bit n = digit n.
REQ-011 Port: LES  output  4  reconstructed enable bits; bit n = digit n.
REQ-012 Port: Valid  output  1  a full frame has been captured since the last reset, error or timeout.
REQ-013 Port: FrameDone  output  1  one-cycle pulse when all four digits have been captured in the current frame.
REQ-014 Port: Err  output  1  one-cycle pulse on a stable illegal AN pattern.
REQ-015 Port: ErrCnt  output  8  saturating count of Err pulses.
REQ-016 Port: Stale  output  1  no capture for TIMEOUT cycles.

Function
REQ-017 AN, HEX, P and LE SHALL be registered once on entry (AN_q, HEX_q, P_q, LE_q); all decoding uses the registered copies.
REQ-018 AN_q decode SHALL be: 1110 -> digit 0; 1101 -> 1; 1011 -> 2; 0111 -> 3; 1111 -> idle; any other pattern -> illegal.
REQ-019 A dwell counter SHALL clear to 0 on every edge where AN_q changes and otherwise increment, saturating at SETTLE.
REQ-020 On the edge where the dwell counter goes from SETTLE-1 to SETTLE with a legal digit decoded, digit n's slot (Hexs nibble, Point[n], LES[n]) SHALL load HEX_q, P_q, LE_q; this is one capture per dwell.
REQ-021 Input-to-output latency SHALL be SETTLE+1 clocks from AN/HEX presented at the inputs to the slot update; HEX changes later within the same dwell SHALL be ignored.
REQ-022 A 4-bit frame mask SHALL set bit n on each capture of digit n; uncaptured slots hold their previous values.
REQ-023 When a capture makes the frame mask 1111, FrameDone SHALL pulse on the following cycle, the mask SHALL clear to 0000, and Valid SHALL set; Valid is sticky.
REQ-024 Capture order SHALL be free; repeated captures of one digit before the mask completes are legal and overwrite the slot.
REQ-025 Idle (1111) SHALL never capture and SHALL not count as an error.
REQ-026 A stable illegal pattern (same SETTLE-crossing rule as REQ-020) SHALL pulse Err once per dwell, increment ErrCnt (saturating at 255), clear the frame mask and Valid, and leave Hexs/Point/LES unchanged.
REQ-027 A stale counter SHALL clear on every capture and otherwise increment; on reaching TIMEOUT, Stale SHALL assert and Valid and the frame mask SHALL clear; Stale deasserts on the next capture.
REQ-028 If a capture and a stale-counter expiry fall on the same edge, the capture SHALL win: Stale stays 0.

Reset
REQ-029 While rst=1, all registers SHALL be cleared asynchronously: Hexs=0, Point=0, LES=0, Valid=0, FrameDone=0, Err=0, ErrCnt=0, Stale=0, frame mask=0, counters=0, AN_q=1111.
REQ-030 Reset asserted mid-dwell or mid-frame SHALL discard the partial frame; capture resumes under REQ-020 timing after release.

Verification
REQ-031 Scan AN=1110,1101,1011,0111 with HEX=1,2,3,4, P=1,0,0,1, LE=1111, 8 cycles each, SETTLE=2 -> Hexs=16'h4321, Point=1001, LES=1111, one FrameDone pulse, Valid=1.
REQ-032 Hold AN=1110 for 1 cycle only, then 1111 (SETTLE=2) -> no capture, Hexs unchanged, no Err.
REQ-033 Hold AN=1100 for 5 cycles after a valid frame -> Err pulses once, ErrCnt=1, Valid=0, Hexs unchanged.
REQ-034 Hold AN=1111 for TIMEOUT cycles after a valid frame -> Stale=1, Valid=0; the next digit capture -> Stale=0.
REQ-035 Assert rst for 1 cycle with two digits captured -> all outputs 0; a fresh full scan after release -> FrameDone pulses exactly once.
REQ-036 Change HEX from 5 to 9 three cycles into a 6-cycle AN=1101 dwell -> Hexs[7:4]=5.
